// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: display bus between a value source and the scan controller.
// master drives value/load; slave (the controller) drives the scan outputs.
interface seg_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                pending;
    logic [3:0]          data;
    logic [DIGITS-1:0]   an;
    logic                frame;

    modport master (
        output value, load,
        input  pending, data, an, frame
    );

    modport slave (
        input  value, load,
        output pending, data, an, frame
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-seg digit scanner with blanking and tear-free update.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZB_EN.
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 16
) (
    input  logic            clk,
    input  logic            rst,
    seg_scan_ctrl_if.slave  bus
);
    localparam int SW = $clog2(PRESCALE);
    localparam int DW = $clog2(DIGITS);
    localparam int VW = 4 * DIGITS;

    localparam logic [SW-1:0] S_LAST  = SW'(PRESCALE - 1);
    localparam logic [SW-1:0] S_BLANK = SW'(BLANK);
    localparam logic [DW-1:0] D_LAST  = DW'(DIGITS - 1);

    logic [SW-1:0]     r_s;
    logic [DW-1:0]     r_d;
    logic [VW-1:0]     r_shadow;
    logic [VW-1:0]     r_display;
    logic              r_pending;

    logic              w_slot_end;
    logic              w_frame;
    logic [3:0]        w_data;
    logic [DIGITS-1:0] w_an;
    logic [DIGITS-1:0] w_lit;

    assign w_slot_end = (r_s == S_LAST);
    assign w_frame    = w_slot_end && (r_d == D_LAST);

    // Slot timer and digit index advance continuously with no idle gaps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s <= '0;
            r_d <= '0;
        end else if (w_slot_end) begin
            r_s <= '0;
            r_d <= (r_d == D_LAST) ? '0 : r_d + 1'b1;
        end else begin
            r_s <= r_s + 1'b1;
        end
    end

    // Shadow capture; display only changes on the frame boundary so no frame tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow  <= '0;
            r_display <= '0;
            r_pending <= 1'b0;
        end else if (bus.load && w_frame) begin
            r_shadow  <= bus.value;
            r_display <= bus.value;
            r_pending <= 1'b0;
        end else if (bus.load) begin
            r_shadow  <= bus.value;
            r_pending <= 1'b1;
        end else if (w_frame && r_pending) begin
            r_display <= r_shadow;
            r_pending <= 1'b0;
        end
    end

`ifdef SEG_SCAN_LZB_EN
    // A digit is lit if it or any more significant nibble is nonzero; digit 0 always.
    always_comb begin
        logic w_any;
        w_any = 1'b0;
        w_lit = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_any    = w_any | (|r_display[4*i +: 4]);
            w_lit[i] = (i == 0) ? 1'b1 : w_any;
        end
    end
`else
    assign w_lit = '1;
`endif

    // Nibble select and active-low enable for the current digit.
    always_comb begin
        w_data = '0;
        w_an   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_d == DW'(i)) begin
                w_data = r_display[4*i +: 4];
                if (r_s >= S_BLANK && w_lit[i]) begin
                    w_an[i] = 1'b0;
                end
            end
        end
    end

    assign bus.data    = w_data;
    assign bus.an      = w_an;
    assign bus.frame   = w_frame;
    assign bus.pending = r_pending;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, is the number of multiplexed digits (2..8).
REQ-002 Parameter PRESCALE, default 1000, is the number of clock cycles per digit slot (>= BLANK+1).
REQ-003 Parameter BLANK, default 16, is the number of anti-ghost blanking cycles at the start of each slot (>= 1).
REQ-004 clk  input  1  single system clock, rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 value  input  4*DIGITS  nibbles to display; nibble i (bits 4i+3..4i) is digit i, digit 0 least significant.
REQ-007 load  input  1  single-cycle strobe; captures value into the shadow register.
REQ-008 pending  output  1  high while a captured value awaits transfer to the display register.
REQ-009 data  output  4  nibble of the active digit, fed to the shared hex-to-segment decoder.
REQ-010 an  output  DIGITS  digit enables, active-low; at most one bit low at any time.
REQ-011 frame  output  1  one-cycle pulse in the last cycle of digit DIGITS-1's slot.

Function
REQ-012 Internal state SHALL be: slot counter s (0..PRESCALE-1), digit index d (0..DIGITS-1), shadow register, display register and pending flag, all registered; outputs are Moore functions of this state.
REQ-013 s SHALL increment every cycle and wrap from PRESCALE-1 to 0; d SHALL increment on that wrap and wrap from DIGITS-1 to 0.
REQ-014 data SHALL equal display nibble d throughout the whole slot, including blanking.
REQ-015 an[d] SHALL be 0 when s >= BLANK and all other an bits 1; all an bits SHALL be 1 when s < BLANK.
REQ-016 frame SHALL be 1 exactly when s == PRESCALE-1 and d == DIGITS-1.
REQ-017 load SHALL write value into the shadow register and set pending on the next edge; a load while pending is already set overwrites the shadow (last load wins).
REQ-018 On the edge where frame is 1, if pending is set, the shadow SHALL be copied to the display register and pending cleared, so a displayed frame is never torn.
REQ-019 A load in the same cycle as frame SHALL write value directly into both shadow and display registers, leaving pending 0.
REQ-020 load held high for multiple cycles SHALL be treated as repeated loads; no error state exists.
REQ-021 Frame period SHALL be exactly DIGITS*PRESCALE cycles with no idle gaps.

Reset
REQ-022 While rst is sampled high: s=0, d=0, shadow=0, display=0, pending=0; hence data=0, an all 1, frame=0.
REQ-023 rst asserted mid-frame SHALL abort the scan and discard any pending load; scanning restarts at digit 0, s=0 on the first cycle after rst falls.
REQ-024 load sampled in the same cycle as rst SHALL be ignored.

Configuration
REQ-025 Macro SEG_SCAN_LZB_EN, when defined, SHALL enable leading-zero blanking: an stays all 1 during the slot of any digit i > 0 whose display nibble and all nibbles above it are zero; digit 0 is always lit.
REQ-026 Without SEG_SCAN_LZB_EN every digit SHALL be lit per REQ-015, and no blanking logic is present.

Verification (DIGITS=4, PRESCALE=8, BLANK=2; cycle 0 = first cycle after rst falls)
REQ-027 Reset release -> cycles 0-1 an=1111, data=0; cycles 2-7 an=1110; cycles 10-15 an=1101; frame=1 at cycle 31 only, then every 32 cycles.
REQ-028 load with value=16'h1234 at cycle 3 -> pending=1 from cycle 4 to 31; pending=0 at cycle 32; data=4 in cycles 32-39, 3 in 40-47, 2 in 48-55, 1 in 56-63.
REQ-029 loads with 16'hAAAA at cycle 5 and 16'h5555 at cycle 20 -> display at cycle 32 is 16'h5555; 16'hAAAA never appears on data.
REQ-030 load with 16'hBEEF at cycle 31 (frame cycle) -> pending stays 0; data=F in cycles 32-39.
REQ-031 rst pulsed at cycle 18 with a load pending -> pending=0, an=1111 in the cycle after rst falls; display remains 0.
REQ-032 With SEG_SCAN_LZB_EN, display 16'h0050 -> an=1111 during digit 2 and 3 slots; digits 0 and 1 lit with data 0 and 5.
